gpio_ctrl_irq: RTL

//  Parametrised Wishbone-slave GPIO controller: GPIO_WIDTH-bit out/OE/in, atomic set/clear

---
 rtl/gpio_ctrl_irq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/gpio_ctrl_irq.sv
// rtl/gpio_ctrl_irq.sv - Wishbone GPIO controller with synchroniser and per-pin edge/level interrupts
// Optional per-pin input debounce filter is built when GPIO_DEBOUNCE_EN is defined.
`timescale 1ns/1ps
module gpio_ctrl_irq #(
   parameter logic [16:0] MODULE_OFFSET     = 17'h0_1000,
   parameter logic [31:0] DEFAULT_REG_VALUE = 32'hFAB_DEF_AC,
   parameter int          GPIO_WIDTH        = 32,
   parameter int          SYNC_STAGES       = 2
) (
   input  logic                  WBs_CLK_i,
   input  logic                  WBs_RST_i,
   input  logic [16:0]           WBs_ADR_i,
   input  logic                  WBs_CYC_i,
   input  logic                  WBs_STB_i,
   input  logic                  WBs_WE_i,
   input  logic [3:0]            WBs_BYTE_STB_i,
   input  logic [31:0]           WBs_DAT_i,
   output logic [31:0]           WBs_DAT_o,
   output logic                  WBs_ACK_o,
   input  logic [GPIO_WIDTH-1:0] GPIO_in_i,
   output logic [GPIO_WIDTH-1:0] GPIO_out_o,
   output logic [GPIO_WIDTH-1:0] GPIO_OE_o,
   output logic                  Interrupt_o
);

   localparam logic [5:0] W_IN     = 6'd0;
   localparam logic [5:0] W_OUT    = 6'd1;
   localparam logic [5:0] W_OE     = 6'd2;
   localparam logic [5:0] W_SET    = 6'd3;
   localparam logic [5:0] W_CLR    = 6'd4;
   localparam logic [5:0] W_EN     = 6'd5;
   localparam logic [5:0] W_TYPE   = 6'd6;
   localparam logic [5:0] W_POL    = 6'd7;
   localparam logic [5:0] W_STATUS = 6'd8;
`ifdef GPIO_DEBOUNCE_EN
   localparam logic [5:0] W_DEB    = 6'd9;
`endif

   logic                  decode, ack_nxt, wr_en, unused_adr;
   logic [5:0]            word_sel;
   logic [31:0]           be_mask, wr_bits;
   logic [GPIO_WIDTH-1:0] wr_w;
   logic [GPIO_WIDTH-1:0] out_q, oe_q, en_q, type_q, pol_q, status_q, in_prev_q;
   logic [GPIO_WIDTH-1:0] synced, in_val, rise, fall, edge_hit, w1c, status_nxt;
   logic [GPIO_WIDTH-1:0] sync_q [SYNC_STAGES];

   function automatic logic [GPIO_WIDTH-1:0] merge_be(input logic [GPIO_WIDTH-1:0] cur,
                                                      input logic [31:0] mask,
                                                      input logic [31:0] bits);
      return GPIO_WIDTH'((32'(cur) & ~mask) | bits);
   endfunction

   assign decode     = (WBs_ADR_i[16:8] == MODULE_OFFSET[16:8]);
   assign ack_nxt    = decode & WBs_CYC_i & WBs_STB_i & ~WBs_ACK_o;
   assign wr_en      = ack_nxt & WBs_WE_i;
   assign word_sel   = WBs_ADR_i[7:2];
   assign unused_adr = ^WBs_ADR_i[1:0];
   assign be_mask    = {{8{WBs_BYTE_STB_i[3]}}, {8{WBs_BYTE_STB_i[2]}},
                        {8{WBs_BYTE_STB_i[1]}}, {8{WBs_BYTE_STB_i[0]}}};
   assign wr_bits    = WBs_DAT_i & be_mask;
   assign wr_w       = GPIO_WIDTH'(wr_bits);

   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      end else begin
         sync_q[0] <= GPIO_in_i;
         for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      end
   end
   assign synced = sync_q[SYNC_STAGES-1];

`ifdef GPIO_DEBOUNCE_EN
   logic [15:0]           deb_q;
   logic [15:0]           cnt_q [GPIO_WIDTH];
   logic [GPIO_WIDTH-1:0] filt_q;

   // A pin's filtered value only follows after DEBOUNCE+1 consecutive differing samples.
   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         deb_q  <= '0;
         filt_q <= '0;
         for (int i = 0; i < GPIO_WIDTH; i++) cnt_q[i] <= '0;
      end else begin
         if (wr_en && word_sel == W_DEB) deb_q <= 16'((32'(deb_q) & ~be_mask) | wr_bits);
         for (int i = 0; i < GPIO_WIDTH; i++) begin
            if (synced[i] != filt_q[i]) begin
               if (cnt_q[i] == deb_q) begin
                  filt_q[i] <= synced[i];
                  cnt_q[i]  <= '0;
               end else begin
                  cnt_q[i]  <= cnt_q[i] + 16'd1;
               end
            end else begin
               cnt_q[i] <= '0;
            end
         end
      end
   end
   assign in_val = filt_q;
`else
   assign in_val = synced;
`endif

   // Edge pins are sticky with set-over-clear priority; level pins mirror the input.
   always_comb begin
      rise       = in_val & ~in_prev_q;
      fall       = ~in_val & in_prev_q;
      edge_hit   = type_q & ((pol_q & rise) | (~pol_q & fall));
      w1c        = (wr_en && word_sel == W_STATUS) ? wr_w : '0;
      status_nxt = (type_q & ((status_q & ~w1c) | edge_hit)) | (~type_q & ~(in_val ^ pol_q));
   end

   always_ff @(posedge WBs_CLK_i or posedge WBs_RST_i) begin
      if (WBs_RST_i) begin
         WBs_ACK_o   <= 1'b0;
         out_q       <= '0;
         oe_q        <= '0;
         en_q        <= '0;
         type_q      <= '0;
         pol_q       <= '0;
         status_q    <= '0;
         in_prev_q   <= '0;
         Interrupt_o <= 1'b0;
      end else begin
         WBs_ACK_o   <= ack_nxt;
         in_prev_q   <= in_val;
         status_q    <= status_nxt;
         Interrupt_o <= |(status_q & en_q);
         if (wr_en) begin
            case (word_sel)
               W_OUT:   out_q  <= merge_be(out_q, be_mask, wr_bits);
               W_OE:    oe_q   <= merge_be(oe_q, be_mask, wr_bits);
               W_SET:   out_q  <= out_q | wr_w;
               W_CLR:   out_q  <= out_q & ~wr_w;
               W_EN:    en_q   <= merge_be(en_q, be_mask, wr_bits);
               W_TYPE:  type_q <= merge_be(type_q, be_mask, wr_bits);
               W_POL:   pol_q  <= merge_be(pol_q, be_mask, wr_bits);
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      WBs_DAT_o = DEFAULT_REG_VALUE;
      case (word_sel)
         W_IN:         WBs_DAT_o = 32'(in_val);
         W_OUT:        WBs_DAT_o = 32'(out_q);
         W_OE:         WBs_DAT_o = 32'(oe_q);
         W_SET, W_CLR: WBs_DAT_o = 32'h0;
         W_EN:         WBs_DAT_o = 32'(en_q);
         W_TYPE:       WBs_DAT_o = 32'(type_q);
         W_POL:        WBs_DAT_o = 32'(pol_q);
         W_STATUS:     WBs_DAT_o = 32'(status_q);
`ifdef GPIO_DEBOUNCE_EN
         W_DEB:        WBs_DAT_o = {16'h0, deb_q};
`endif
         default:      ;
      endcase
   end

   assign GPIO_out_o = out_q;
   assign GPIO_OE_o  = oe_q;

endmodule
